// File: rtl/dac_spi_multi.sv
// Multi-channel SPI DAC streamer: one packed sample set per handshake, one
// chip-select window per channel, optional shared latch strobe at the end.
module dac_spi_multi #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 12,
  parameter int HDR_W      = 4,
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 2,
  parameter int LATCH_LEN  = 2,
  parameter int SYNC_LATCH = 1,
  localparam int HW        = (HDR_W > 0) ? HDR_W : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH*HW-1:0]     in_hdr,
  output logic                     dac_mosi,
  output logic                     dac_sclk,
  output logic                     dac_csn,
  output logic                     dac_latchn,
  output logic                     busy,
  output logic                     frame_done,
  output logic [2:0]               state_dbg
);

  // Handshake: a set transfers on any clk edge where in_valid && in_ready;
  // in_ready is high only in IDLE and DONE, and in_valid may be held across sets.

  localparam int F       = HDR_W + DATA_W;
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? ((CLK_DIV > LATCH_LEN) ? CLK_DIV : LATCH_LEN)
                                              : ((CS_GAP > LATCH_LEN) ? CS_GAP : LATCH_LEN);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = (F > 1) ? $clog2(F) : 1;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_GAP   = 3'd2,
    S_LATCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [BIT_W-1:0]         bit_cnt;
  logic [CH_W-1:0]          ch_cnt;
  logic [F-1:0]             shreg;
  logic [NUM_CH*DATA_W-1:0] data_q;
  logic [NUM_CH*HW-1:0]     hdr_q;
  logic [F-1:0]             in_frame;
  logic [F-1:0]             q_frame;

  // The captured set is shifted down one channel per frame, so the next
  // channel's frame always sits in the low slot.
  generate
    if (HDR_W > 0) begin : g_hdr
      assign in_frame = {in_hdr[HDR_W-1:0], in_data[DATA_W-1:0]};
      assign q_frame  = {hdr_q[HDR_W-1:0], data_q[DATA_W-1:0]};
    end else begin : g_nohdr
      assign in_frame = in_data[DATA_W-1:0];
      assign q_frame  = data_q[DATA_W-1:0];
    end
  endgenerate

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      ch_cnt     <= '0;
      shreg      <= '0;
      data_q     <= '0;
      hdr_q      <= '0;
      in_ready   <= 1'b0;
      dac_mosi   <= 1'b0;
      dac_sclk   <= 1'b0;
      dac_csn    <= 1'b1;
      dac_latchn <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          frame_done <= 1'b0;
          if (in_valid && in_ready) begin
            state    <= S_SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            dac_csn  <= 1'b0;
            dac_sclk <= 1'b0;
            dac_mosi <= in_frame[F-1];
            shreg    <= in_frame;
            data_q   <= in_data >> DATA_W;
            hdr_q    <= in_hdr >> HDR_W;
            cnt      <= '0;
            bit_cnt  <= '0;
            ch_cnt   <= '0;
          end else begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt <= '0;
            if (!dac_sclk) begin
              dac_sclk <= 1'b1;
            end else if (bit_cnt == BIT_W'(F - 1)) begin
              state    <= S_GAP;
              dac_csn  <= 1'b1;
              dac_sclk <= 1'b0;
              dac_mosi <= 1'b0;
            end else begin
              dac_sclk <= 1'b0;
              bit_cnt  <= bit_cnt + 1'b1;
              shreg    <= shreg << 1;
              dac_mosi <= shreg[F-2];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == CNT_W'(CS_GAP - 1)) begin
            cnt <= '0;
            if (ch_cnt == CH_W'(NUM_CH - 1)) begin
              if (SYNC_LATCH != 0) begin
                state      <= S_LATCH;
                dac_latchn <= 1'b0;
              end else begin
                state      <= S_DONE;
                frame_done <= 1'b1;
                busy       <= 1'b0;
                in_ready   <= 1'b1;
              end
            end else begin
              state    <= S_SHIFT;
              ch_cnt   <= ch_cnt + 1'b1;
              dac_csn  <= 1'b0;
              dac_mosi <= q_frame[F-1];
              shreg    <= q_frame;
              data_q   <= data_q >> DATA_W;
              hdr_q    <= hdr_q >> HDR_W;
              bit_cnt  <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LATCH: begin
          if (cnt == CNT_W'(LATCH_LEN - 1)) begin
            cnt        <= '0;
            state      <= S_DONE;
            dac_latchn <= 1'b1;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_multi.sv
// Bench for dac_spi_multi: default, no-latch and 4-channel instances, with a
// frame-level reference model built from the channel packing and period formula.
module tb_dac_spi_multi;

  localparam int CLK_DIV     = 4;
  localparam int CS_GAP      = 2;
  localparam int T_D         = 263;
  localparam int LATCH_START = 261;
  localparam int T_NL        = 261;
  localparam int T_W         = 139;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // default instance
  logic        d_reset = 1'b1, d_valid = 1'b0;
  logic [23:0] d_data = '0;
  logic [7:0]  d_hdr = '0;
  logic        d_ready, d_mosi, d_sclk, d_csn, d_latchn, d_busy, d_done;
  logic [2:0]  d_state;

  dac_spi_multi u_def (
    .clk(clk), .reset(d_reset), .in_valid(d_valid), .in_ready(d_ready),
    .in_data(d_data), .in_hdr(d_hdr), .dac_mosi(d_mosi), .dac_sclk(d_sclk),
    .dac_csn(d_csn), .dac_latchn(d_latchn), .busy(d_busy), .frame_done(d_done),
    .state_dbg(d_state)
  );

  // no latch phase
  logic        n_reset = 1'b1, n_valid = 1'b0;
  logic [23:0] n_data = '0;
  logic [7:0]  n_hdr = '0;
  logic        n_ready, n_mosi, n_sclk, n_csn, n_latchn, n_busy, n_done;
  logic [2:0]  n_state;

  dac_spi_multi #(.SYNC_LATCH(0)) u_nl (
    .clk(clk), .reset(n_reset), .in_valid(n_valid), .in_ready(n_ready),
    .in_data(n_data), .in_hdr(n_hdr), .dac_mosi(n_mosi), .dac_sclk(n_sclk),
    .dac_csn(n_csn), .dac_latchn(n_latchn), .busy(n_busy), .frame_done(n_done),
    .state_dbg(n_state)
  );

  // four channels, no header, fastest SCLK
  logic        w_reset = 1'b1, w_valid = 1'b0;
  logic [63:0] w_data = '0;
  logic [3:0]  w_hdr = '0;
  logic        w_ready, w_mosi, w_sclk, w_csn, w_latchn, w_busy, w_done;
  logic [2:0]  w_state;

  dac_spi_multi #(.NUM_CH(4), .DATA_W(16), .HDR_W(0), .CLK_DIV(1)) u_wide (
    .clk(clk), .reset(w_reset), .in_valid(w_valid), .in_ready(w_ready),
    .in_data(w_data), .in_hdr(w_hdr), .dac_mosi(w_mosi), .dac_sclk(w_sclk),
    .dac_csn(w_csn), .dac_latchn(w_latchn), .busy(w_busy), .frame_done(w_done),
    .state_dbg(w_state)
  );

  logic [15:0] exp_q[$];
  int          done_q[$];
  int          latch_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_d(input logic [23:0] data, input logic [7:0] hdr,
                        input bit expect_it, output int hs);
    d_valid = 1'b1;
    d_data  = data;
    d_hdr   = hdr;
    hs      = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (d_ready) begin
        hs = cyc;
        break;
      end
    end
    check("accept", 32'(hs >= 0), 1);
    if (hs >= 0 && expect_it) begin
      for (int c = 0; c < 2; c++) exp_q.push_back({hdr[c*4 +: 4], data[c*12 +: 12]});
      latch_q.push_back(hs + LATCH_START);
      done_q.push_back(hs + T_D);
    end
  endtask

  // default instance monitor: waveform timing plus frame scoreboard
  logic        p_csn = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, p_latchn = 1'b1, p_busy = 1'b0, p_reset = 1'b1;
  int          hi_run = 0, lo_run = 0, gap_run = 0, lat_run = 0, nbits = 0;
  logic [31:0] word = '0;

  always @(negedge clk) begin
    if (d_reset || p_reset) begin
      hi_run = 0; lo_run = 0; gap_run = 0; lat_run = 0; nbits = 0; word = '0;
    end else begin
      if (!d_csn) begin
        if (p_csn) begin
          if (p_busy) check("cs_gap_len", gap_run, CS_GAP);
          nbits = 0; word = '0; lo_run = 0; hi_run = 0;
        end
        if (d_sclk && !p_sclk) begin
          check("mosi_stable_at_rise", d_mosi, p_mosi);
          check("sclk_low_len", lo_run, CLK_DIV);
          word = {word[30:0], d_mosi};
          nbits++;
          hi_run = 0;
        end
        if (!d_sclk && p_sclk) begin
          check("sclk_high_len", hi_run, CLK_DIV);
          lo_run = 0;
        end
        if (d_sclk) hi_run++; else lo_run++;
      end else begin
        check("sclk_idle_low", d_sclk, 0);
        check("mosi_idle_low", d_mosi, 0);
        if (!p_csn) begin
          check("last_high_len", hi_run, CLK_DIV);
          check("rise_count", nbits, 16);
          check("frame_expected", exp_q.size(), (exp_q.size() > 0) ? exp_q.size() : 1);
          if (exp_q.size() > 0) check("frame_bits", word[15:0], exp_q.pop_front());
          gap_run = 0;
        end
        gap_run++;
      end
      if (!d_latchn) begin
        if (p_latchn) begin
          check("latch_expected", latch_q.size(), (latch_q.size() > 0) ? latch_q.size() : 1);
          if (latch_q.size() > 0) check("latch_start", cyc, latch_q.pop_front());
          lat_run = 0;
        end
        lat_run++;
      end else if (!p_latchn) begin
        check("latch_len", lat_run, 2);
      end
      if (d_done) begin
        check("done_expected", done_q.size(), (done_q.size() > 0) ? done_q.size() : 1);
        if (done_q.size() > 0) check("done_cycle", cyc, done_q.pop_front());
      end
    end
    p_csn = d_csn; p_sclk = d_sclk; p_mosi = d_mosi; p_latchn = d_latchn;
    p_busy = d_busy; p_reset = d_reset;
  end

  // lightweight capture for the other two instances
  logic        np_csn = 1'b1, np_sclk = 1'b0, wp_csn = 1'b1, wp_sclk = 1'b0;
  logic [31:0] n_word = '0, w_word = '0;
  logic [31:0] n_got[$], w_got[$];
  int          w_len[$], n_done_q[$], w_done_q[$];
  int          n_latch_lo = 0, w_win = 0;

  always @(negedge clk) begin
    if (!n_reset) begin
      if (!n_csn && np_csn) n_word = '0;
      if (!n_csn && n_sclk && !np_sclk) n_word = {n_word[30:0], n_mosi};
      if (n_csn && !np_csn) n_got.push_back(n_word);
      if (!n_latchn) n_latch_lo++;
      if (n_done) n_done_q.push_back(cyc);
    end
    if (!w_reset) begin
      if (!w_csn && wp_csn) begin w_word = '0; w_win = 0; end
      if (!w_csn) w_win++;
      if (!w_csn && w_sclk && !wp_sclk) w_word = {w_word[30:0], w_mosi};
      if (w_csn && !wp_csn) begin w_got.push_back(w_word); w_len.push_back(w_win); end
      if (w_done) w_done_q.push_back(cyc);
    end
    np_csn = n_csn; np_sclk = n_sclk; wp_csn = w_csn; wp_sclk = w_sclk;
  end

  initial begin
    int hs, hs2, hs3;
    logic [23:0] sd[3];
    logic [7:0]  sh[3];
    logic [15:0] wexp[4];

    repeat (3) @(negedge clk);
    check("rst_ready", d_ready, 0);
    check("rst_csn", d_csn, 1);
    check("rst_latchn", d_latchn, 1);
    check("rst_sclk", d_sclk, 0);
    check("rst_mosi", d_mosi, 0);
    check("rst_busy", d_busy, 0);
    check("rst_done", d_done, 0);
    @(posedge clk); #1;
    d_reset = 1'b0; n_reset = 1'b0; w_reset = 1'b0;
    @(negedge clk); check("ready_at_release", d_ready, 0);
    @(negedge clk); check("ready_after_release", d_ready, 1);

    // directed set with known bit streams
    @(posedge clk); #1;
    send_d(24'h123ABC, 8'hB3, 1, hs);
    @(posedge clk); #1;
    d_valid = 1'b0; d_data = 24'($urandom); d_hdr = 8'($urandom);
    @(negedge clk);
    check("busy_after_accept", d_busy, 1);
    check("ready_after_accept", d_ready, 0);
    check("csn_after_accept", d_csn, 0);
    repeat (261) @(negedge clk);
    check("busy_in_latch", d_busy, 1);
    check("latchn_in_latch", d_latchn, 0);
    @(negedge clk);
    check("busy_at_done", d_busy, 0);
    check("ready_at_done", d_ready, 1);
    check("done_pulse", d_done, 1);
    @(negedge clk);
    check("done_one_cycle", d_done, 0);
    check("ready_idle", d_ready, 1);

    // three back-to-back sets with in_valid held
    for (int k = 0; k < 3; k++) begin
      sd[k] = 24'($urandom);
      sh[k] = 8'($urandom);
    end
    @(posedge clk); #1;
    send_d(sd[0], sh[0], 1, hs);
    @(posedge clk); #1;
    send_d(sd[1], sh[1], 1, hs2);
    check("b2b_period_1", hs2 - hs, T_D);
    @(posedge clk); #1;
    send_d(sd[2], sh[2], 1, hs3);
    check("b2b_period_2", hs3 - hs2, T_D);
    @(posedge clk); #1;
    d_valid = 1'b0; d_data = 24'($urandom);
    repeat (T_D + 5) @(negedge clk);

    // reset in the middle of channel 0
    @(posedge clk); #1;
    send_d(24'($urandom), 8'($urandom), 0, hs);
    @(posedge clk); #1;
    d_valid = 1'b0;
    while (cyc < hs + 70) begin
      @(posedge clk); #1;
    end
    d_reset = 1'b1;
    @(posedge clk); #1;
    d_reset = 1'b0;
    @(negedge clk);
    check("abort_csn", d_csn, 1);
    check("abort_sclk", d_sclk, 0);
    check("abort_latchn", d_latchn, 1);
    check("abort_ready", d_ready, 0);
    check("abort_busy", d_busy, 0);
    check("abort_mosi", d_mosi, 0);
    @(negedge clk);
    check("abort_ready_back", d_ready, 1);
    @(posedge clk); #1;
    send_d(24'($urandom), 8'($urandom), 1, hs);
    @(posedge clk); #1;
    d_valid = 1'b0;
    repeat (T_D + 5) @(negedge clk);

    // SYNC_LATCH = 0
    @(posedge clk); #1;
    n_valid = 1'b1; n_data = 24'($urandom); n_hdr = 8'($urandom); hs = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (n_ready) begin hs = cyc; break; end
    end
    check("nl_accept", 32'(hs >= 0), 1);
    @(posedge clk); #1;
    n_valid = 1'b0;
    for (int i = 0; i < T_NL + 20 && n_done_q.size() == 0; i++) @(negedge clk);
    check("nl_done_seen", n_done_q.size(), 1);
    if (n_done_q.size() > 0) check("nl_done_cycle", n_done_q.pop_front() - hs, T_NL);
    check("nl_frames", n_got.size(), 2);
    for (int c = 0; c < 2 && c < n_got.size(); c++)
      check("nl_frame_bits", n_got[c], {16'h0, n_hdr[c*4 +: 4], n_data[c*12 +: 12]});
    check("nl_latch_never_low", n_latch_lo, 0);

    // four channels, CLK_DIV = 1, no header
    wexp[0] = 16'h8001; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000; wexp[3] = 16'h5A5A;
    @(posedge clk); #1;
    w_valid = 1'b1; w_data = {wexp[3], wexp[2], wexp[1], wexp[0]}; hs = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (w_ready) begin hs = cyc; break; end
    end
    check("w_accept", 32'(hs >= 0), 1);
    @(posedge clk); #1;
    w_valid = 1'b0; w_data = 64'({$urandom, $urandom});
    for (int i = 0; i < T_W + 20 && w_done_q.size() == 0; i++) @(negedge clk);
    check("w_done_seen", w_done_q.size(), 1);
    if (w_done_q.size() > 0) check("w_done_cycle", w_done_q.pop_front() - hs, T_W);
    check("w_frames", w_got.size(), 4);
    for (int c = 0; c < 4 && c < w_got.size(); c++) begin
      check("w_frame_bits", w_got[c], {16'h0, wexp[c]});
      check("w_window_len", w_len[c], 32);
    end

    check("frames_drained", exp_q.size(), 0);
    check("latches_drained", latch_q.size(), 0);
    check("dones_drained", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_spi_multi.md
Name: dac_spi_multi

Overview:
- Parametrised multi-channel SPI DAC streamer for the laser projector; successor to the fixed two-axis galvo DAC path.
- Accepts one packed sample set (NUM_CH channels) per valid/ready handshake.
- Serialises each channel as a header+data SPI frame with its own chip-select window.
- Optionally pulses the DAC latch once per set, so all galvo/colour outputs update simultaneously.

Parameters:
- NUM_CH, 2: number of DAC channels per sample set (>=1).
- DATA_W, 12: data bits per channel.
- HDR_W, 4: header/command bits sent ahead of the data (>=0).
- CLK_DIV, 4: clk cycles per SCLK half-period (>=1).
- CS_GAP, 2: clk cycles dac_csn stays high between channel frames (>=1).
- LATCH_LEN, 2: clk cycles dac_latchn is held low (>=1).
- SYNC_LATCH, 1: 1 = pulse dac_latchn after the last channel; 0 = dac_latchn held high, no latch phase.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  sample set available.
- in_ready  out  1  block idle; set accepted when in_valid & in_ready.
- in_data  in  NUM_CH*DATA_W  channel c in bits [c*DATA_W +: DATA_W].
- in_hdr  in  NUM_CH*HDR_W  channel c header in bits [c*HDR_W +: HDR_W].
- dac_mosi  out  1  serial data, MSB first.
- dac_sclk  out  1  SPI clock, mode 0 (idle low).
- dac_csn  out  1  active-low chip select, one low window per channel.
- dac_latchn  out  1  active-low load-DAC strobe.
- busy  out  1  high from the cycle after accept until frame_done.
- frame_done  out  1  one-cycle pulse when the set is complete.

Behaviour:
- All outputs are registered. Reset values: in_ready=0, dac_csn=1, dac_latchn=1, dac_sclk=0, dac_mosi=0, busy=0, frame_done=0. in_ready rises the first cycle after reset is released.
- Frame width F = HDR_W+DATA_W; each frame is {hdr_c, data_c}, MSB first. Channel 0 goes first.
- FSM: IDLE -> SHIFT -> GAP -> (SHIFT for next channel | LATCH | DONE) -> IDLE.
- IDLE: in_ready=1. On handshake at cycle 0, in_data/in_hdr are captured and in_ready drops at cycle 1. Later input changes are ignored.
- SHIFT: dac_csn=0 for exactly 2*CLK_DIV*F cycles.
  - Each bit period is a low phase of CLK_DIV cycles, then a high phase of CLK_DIV cycles.
  - dac_mosi holds the bit for the whole period and changes only when SCLK falls (or on csn fall for the MSB).
  - dac_sclk ends low when csn rises.
- GAP: dac_csn=1, dac_sclk=0 for CS_GAP cycles. dac_mosi=0.
- LATCH (SYNC_LATCH=1 only): dac_latchn=0 for LATCH_LEN cycles after the last GAP.
- DONE: one cycle with frame_done=1, busy=0, in_ready=1. A handshake in this cycle is accepted, and the next csn falls on the following cycle (back-to-back sets).
- Cycle map for defaults (F=16):
  - csn low 1..128, high 129..130.
  - csn low 131..258, high 259..260.
  - latchn low 261..262.
  - frame_done 263.
- General period T = NUM_CH*(2*CLK_DIV*F+CS_GAP) + SYNC_LATCH*LATCH_LEN + 1.
- in_valid while busy: ignored, no state change.
- Reset mid-set: the next cycle all outputs are at reset values. The partial set is discarded, no latch pulse, no frame_done.
- Bit, channel and phase counters are sized by $clog2 of their maxima. No counter wraps inside a set.

Test Plan:
- Defaults, in_hdr={4'hB,4'h3}, in_data={12'h123,12'hABC} -> bits sampled on SCLK rising edges: 16'h3ABC then 16'hB123. Exactly 16 rising edges per csn window. latchn low cycles 261-262. frame_done at cycle 263 only.
- Timing check: SCLK high/low phases exactly 4 cycles each, csn gap exactly 2 cycles, dac_mosi stable across every SCLK rise -> any violation fails.
- in_valid held high with 3 distinct sets -> sets accepted at cycles 0, 263, 526. No idle cycle between sets. Data is not corrupted by in_data changes mid-set.
- reset asserted at cycle 70 (mid channel 0) -> cycle 71: csn=1, sclk=0, latchn=1, in_ready=0. in_ready=1 the cycle after reset drops. No frame_done. A new set then transmits correctly.
- SYNC_LATCH=0 -> latchn constantly 1. frame_done at cycle 261.
- NUM_CH=4, CLK_DIV=1, HDR_W=0, DATA_W=16, data 16'h8001/16'hFFFF/16'h0000/16'h5A5A -> 4 csn windows of 32 cycles each, streams match MSB first. T = 4*34+2+1 = 139.
